// File: rtl/mult35x35_accum_round.sv
// Frame accumulator for the 35x35 multiplier product stream: sums signed
// products over framed bursts, then rounds, shifts, saturates and queues
// each frame result in a 2-entry FIFO with a valid/ready handshake.
module mult35x35_accum_round #(
  parameter int PROD_W = 70,
  parameter int CNT_W  = 11,
  parameter int ACC_W  = 81,
  parameter int SHIFT  = 35,
  parameter int OUT_W  = 35
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic [PROD_W-1:0] PROD_IN,
  input  logic              PROD_VALID,
  input  logic              PROD_LAST,
  output logic [OUT_W-1:0]  RES_OUT,
  output logic              SAT_FLAG,
  output logic [CNT_W-1:0]  TERM_CNT,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic              OVF_ERR
);

  if (ACC_W < PROD_W + CNT_W) begin : g_acc_w_check
    $error("ACC_W must be >= PROD_W + CNT_W");
  end
  if (SHIFT < 1 || SHIFT > ACC_W - 1) begin : g_shift_check
    $error("SHIFT must be in 1..ACC_W-1");
  end

  localparam int ENT_W = OUT_W + CNT_W + 1;
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   prod_ext, sum_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               close;

  logic               s1_valid;
  logic [ACC_W-1:0]   s1_sum;
  logic [CNT_W-1:0]   s1_cnt;
  logic signed [ACC_W:0] rnd_sum, rnd_shr;

  logic               s2_valid;
  logic signed [ACC_W:0] s2_r;
  logic [CNT_W-1:0]   s2_cnt;
  logic [OUT_W-1:0]   sat_res;
  logic               sat_hit;

  logic [ENT_W-1:0]   mem [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic               rd_en, full, wr_acc;

  // Frame FSM next state plus the running sum/count including this beat.
  always_comb begin
    state_nxt = state;
    prod_ext  = {{(ACC_W - PROD_W){PROD_IN[PROD_W-1]}}, PROD_IN};
    sum_nxt   = ((state == S_ACCUM) ? acc : '0) + prod_ext;
    cnt_nxt   = CNT_W'(1);
    if (state == S_ACCUM) cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    close = PROD_VALID & PROD_LAST;
    if (PROD_VALID) state_nxt = PROD_LAST ? S_IDLE : S_ACCUM;
  end

  // Frame state, accumulator and product count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (CLR) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (PROD_VALID) begin
        acc <= PROD_LAST ? '0 : sum_nxt;
        cnt <= PROD_LAST ? '0 : cnt_nxt;
      end
    end
  end

  // Stage 1: capture the closing sum and product count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_cnt   <= '0;
    end else begin
      s1_valid <= close & ~CLR;
      if (close && !CLR) begin
        s1_sum <= sum_nxt;
        s1_cnt <= cnt_nxt;
      end
    end
  end

  // Round half toward +inf, then arithmetic shift; one extra bit absorbs the bias.
  always_comb begin
    rnd_sum = $signed({s1_sum[ACC_W-1], s1_sum}) + HALF;
    rnd_shr = rnd_sum >>> SHIFT;
  end

  // Stage 2: register the rounded, shifted value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_cnt   <= '0;
    end else begin
      s2_valid <= s1_valid & ~CLR;
      if (s1_valid && !CLR) begin
        s2_r   <= rnd_shr;
        s2_cnt <= s1_cnt;
      end
    end
  end

  // Clip to the signed output range and flag clipping.
  always_comb begin
    sat_hit = 1'b0;
    sat_res = s2_r[OUT_W-1:0];
    if (s2_r > MAXV) begin
      sat_hit = 1'b1;
      sat_res = MAXV[OUT_W-1:0];
    end else if (s2_r < MINV) begin
      sat_hit = 1'b1;
      sat_res = MINV[OUT_W-1:0];
    end
    rd_en  = RES_VALID & RES_READY;
    full   = (count == 2'd2);
    wr_acc = s2_valid & (~full | rd_en);
  end

  // Two-entry result FIFO; a write to a full FIFO without a read is dropped.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= '0;
      OVF_ERR <= 1'b0;
    end else if (CLR) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= '0;
      OVF_ERR <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= {sat_hit, s2_cnt, sat_res};
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      unique case ({wr_acc, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (s2_valid && full && !rd_en) OVF_ERR <= 1'b1;
    end
  end

  assign RES_VALID = (count != 2'd0);
  assign {SAT_FLAG, TERM_CNT, RES_OUT} = mem[rd_ptr];

endmodule

// File: tb/tb_mult35x35_accum_round.sv
// Directed self-checking bench for the frame accumulator.
module tb_mult35x35_accum_round;

  logic        CLK = 1'b0;
  logic        RST_N, CLR, PROD_VALID, PROD_LAST, RES_READY;
  logic [69:0] PROD_IN;
  logic [34:0] RES_OUT;
  logic        SAT_FLAG, RES_VALID, OVF_ERR;
  logic [10:0] TERM_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [69:0] X = 70'd1 << 35;

  mult35x35_accum_round #(.PROD_W(70), .CNT_W(11), .ACC_W(81), .SHIFT(35), .OUT_W(35)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .PROD_IN(PROD_IN), .PROD_VALID(PROD_VALID),
    .PROD_LAST(PROD_LAST), .RES_OUT(RES_OUT), .SAT_FLAG(SAT_FLAG), .TERM_CNT(TERM_CNT),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .OVF_ERR(OVF_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic last, input logic [69:0] p);
    PROD_VALID = v;
    PROD_LAST  = last;
    PROD_IN    = p;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CLR = 1'b0; RES_READY = 1'b1;
    drive(1'b0, 1'b0, '0);
    #1;
    n_cmp++;
    if ({RES_VALID, RES_OUT, SAT_FLAG, TERM_CNT, OVF_ERR} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b out=%h cnt=%0d ovf=%0b, want all 0",
               RES_VALID, RES_OUT, TERM_CNT, OVF_ERR);
    end
    tick(); tick();
    RST_N = 1'b1;
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_valid: got %0b want 0", RES_VALID);
    end
  endtask

  task automatic test_single_frame();
    drive(1'b1, 1'b1, 70'd3 * X);
    tick();
    drive(1'b0, 1'b0, '0);
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early_valid: got %0b want 0 one edge after close", RES_VALID);
    end
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd3 || SAT_FLAG !== 1'b0 || TERM_CNT !== 11'd1) begin
      n_bad++;
      $display("FAIL single_frame: got valid=%0b out=%h sat=%0b cnt=%0d want 1/3/0/1",
               RES_VALID, RES_OUT, SAT_FLAG, TERM_CNT);
    end
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drained: got valid=%0b want 0", RES_VALID);
    end
  endtask

  task automatic test_back_to_back();
    logic [69:0] p [3];
    logic [34:0] e [3];
    p[0] = 70'd2 * X + (X >> 1);        e[0] = 35'd3;
    p[1] = 70'd2 * X + (X >> 1) - 70'd1; e[1] = 35'd2;
    p[2] = -(70'd2 * X + (X >> 1));     e[2] = 35'h7FFFFFFFE;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 1'b1, p[c]);
      else drive(1'b0, 1'b0, '0);
      tick();
      if (c >= 2) begin
        n_cmp++;
        if (RES_VALID !== 1'b1 || RES_OUT !== e[c-2]) begin
          n_bad++;
          $display("FAIL rounding_b2b[%0d]: got valid=%0b out=%h want 1/%h",
                   c - 2, RES_VALID, RES_OUT, e[c-2]);
        end
      end
    end
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drained: got valid=%0b want 0", RES_VALID);
    end
  endtask

  task automatic test_gap_frame();
    drive(1'b1, 1'b0, X); tick();
    drive(1'b1, 1'b0, X); tick();
    drive(1'b0, 1'b0, '0); tick(); tick();
    drive(1'b1, 1'b0, X); tick();
    drive(1'b1, 1'b1, X); tick();
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd4 || TERM_CNT !== 11'd4 || SAT_FLAG !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_frame: got valid=%0b out=%h cnt=%0d sat=%0b want 1/4/4/0",
               RES_VALID, RES_OUT, TERM_CNT, SAT_FLAG);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [69:0] a, pp, pn;
    a  = (70'd1 << 34) - 70'd1;
    pp = a * a;
    pn = -((70'd1 << 34) * a);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 3, pp);
      tick();
    end
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'h3FFFFFFFF || SAT_FLAG !== 1'b1 || TERM_CNT !== 11'd4) begin
      n_bad++;
      $display("FAIL sat_pos: got valid=%0b out=%h sat=%0b cnt=%0d want 1/3ffffffff/1/4",
               RES_VALID, RES_OUT, SAT_FLAG, TERM_CNT);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 3, pn);
      tick();
    end
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'h400000000 || SAT_FLAG !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_neg: got valid=%0b out=%h sat=%0b want 1/400000000/1",
               RES_VALID, RES_OUT, SAT_FLAG);
    end
    tick();
  endtask

  task automatic test_backpressure();
    RES_READY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 1'b1, 70'(c + 1) * X);
      else drive(1'b0, 1'b0, '0);
      tick();
    end
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd1 || OVF_ERR !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_full: got valid=%0b out=%h ovf=%0b want 1/1/1", RES_VALID, RES_OUT, OVF_ERR);
    end
    tick();
    n_cmp++;
    if (RES_OUT !== 35'd1 || OVF_ERR !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold: got out=%h ovf=%0b want 1/1", RES_OUT, OVF_ERR);
    end
    RES_READY = 1'b1;
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd2) begin
      n_bad++;
      $display("FAIL bp_second: got valid=%0b out=%h want 1/2", RES_VALID, RES_OUT);
    end
    tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_empty: got valid=%0b want 0 (third result must be dropped)", RES_VALID);
    end
  endtask

  task automatic test_disruption();
    drive(1'b1, 1'b0, 70'd7 * X); tick();
    drive(1'b1, 1'b0, 70'd7 * X); tick();
    CLR = 1'b1;
    drive(1'b1, 1'b1, 70'd7 * X); tick();
    CLR = 1'b0;
    n_cmp++;
    if (OVF_ERR !== 1'b0 || RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_state: got ovf=%0b valid=%0b want 0/0", OVF_ERR, RES_VALID);
    end
    drive(1'b1, 1'b1, 70'd5 * X); tick();
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd5 || TERM_CNT !== 11'd1 || OVF_ERR !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_frame: got valid=%0b out=%h cnt=%0d ovf=%0b want 1/5/1/0",
               RES_VALID, RES_OUT, TERM_CNT, OVF_ERR);
    end
    tick();

    RES_READY = 1'b0;
    drive(1'b1, 1'b1, 70'd6 * X); tick();
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd6) begin
      n_bad++;
      $display("FAIL rst_prefill: got valid=%0b out=%h want 1/6", RES_VALID, RES_OUT);
    end
    drive(1'b1, 1'b0, X); tick();
    drive(1'b1, 1'b1, 70'd9 * X); tick();
    drive(1'b0, 1'b0, '0);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({RES_VALID, RES_OUT, SAT_FLAG, TERM_CNT, OVF_ERR} !== '0) begin
      n_bad++;
      $display("FAIL rst_async: got valid=%0b out=%h cnt=%0d want all 0", RES_VALID, RES_OUT, TERM_CNT);
    end
    tick();
    RST_N = 1'b1;
    RES_READY = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_stale: got valid=%0b out=%h want 0", RES_VALID, RES_OUT);
    end
    drive(1'b1, 1'b1, 70'd5 * X); tick();
    drive(1'b0, 1'b0, '0); tick(); tick();
    n_cmp++;
    if (RES_VALID !== 1'b1 || RES_OUT !== 35'd5 || TERM_CNT !== 11'd1) begin
      n_bad++;
      $display("FAIL rst_frame: got valid=%0b out=%h cnt=%0d want 1/5/1", RES_VALID, RES_OUT, TERM_CNT);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap_frame();
    test_saturation();
    test_backpressure();
    test_disruption();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
